// File: rtl/read_sram_puf_pkg.sv
// rtl/read_sram_puf_pkg.sv - shared SRAM PUF geometry and read-back FSM encoding
package read_sram_puf_pkg;

    localparam int PUF_ADDR_W = 6;
    localparam int PUF_DATA_W = 8;
    localparam int PUF_DEPTH  = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_CSUM    = 3'd4
    } rd_state_e;

endpackage

// File: rtl/read_sram_puf.sv
// rtl/read_sram_puf.sv - streams every SRAM PUF word to the microprocessor with optional XOR checksum
module read_sram_puf
    import read_sram_puf_pkg::*;
#(
    parameter int ADDR_W      = PUF_ADDR_W,
    parameter int DATA_W      = PUF_DATA_W,
    parameter int DEPTH       = PUF_DEPTH,
    parameter bit APPEND_CSUM = 1'b1
) (
    input  logic              uprocessor_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              done
);

    // One extra bit lets DEPTH equal 2**ADDR_W without the counter aliasing.
    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rden_q, rden_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    logic hs;
    logic at_last;

    assign hs      = valid_q && dout_ready;
    assign at_last = (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge uprocessor_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (hs) begin
                    if (!at_last)         state_d = ST_ISSUE;
                    else if (APPEND_CSUM) state_d = ST_CSUM;
                    else                  state_d = ST_IDLE;
                end
            end
            ST_CSUM:    if (hs) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath next values: address issue, byte capture, checksum, handshake.
    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rden_d  = rden_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        csum_d  = csum_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    addr_d = '0;
                    rden_d = 1'b1;
                    csum_d = '0;
                end
            end
            ST_ISSUE: begin
                rden_d = 1'b0;
            end
            ST_CAPTURE: begin
                // Checksum folds here, so stall length cannot affect it.
                dout_d  = ram_q;
                csum_d  = csum_q ^ ram_q;
                valid_d = 1'b1;
                last_d  = at_last && !APPEND_CSUM;
            end
            ST_PRESENT: begin
                if (hs) begin
                    if (!at_last) begin
                        cnt_d   = cnt_q + 1'b1;
                        addr_d  = ADDR_W'(cnt_q + 1'b1);
                        rden_d  = 1'b1;
                        valid_d = 1'b0;
                    end else if (APPEND_CSUM) begin
                        dout_d = csum_q;
                        last_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_CSUM: begin
                if (hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                rden_d  = 1'b0;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            rden_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge uprocessor_clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rden_q  <= rden_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            csum_q  <= csum_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign ram_addr   = addr_q;
    assign ram_rden   = rden_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_read_sram_puf.sv
// tb/tb_read_sram_puf.sv - scoreboard bench for the SRAM PUF read-back engine
module tb_read_sram_puf;
    import read_sram_puf_pkg::*;

    localparam int AW    = PUF_ADDR_W;
    localparam int DW    = PUF_DATA_W;
    localparam int DEPTH = PUF_DEPTH;

    logic clk = 1'b0;
    logic rst, start_a, start_b, abort, dout_ready;

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic          ram_rden_a, ram_rden_b;
    logic [DW-1:0] ram_q_a, ram_q_b;
    logic [DW-1:0] dout_a, dout_b;
    logic          valid_a, valid_b, last_a, last_b, done_a, done_b, busy_a, busy_b;

    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    logic [DW:0] exp_q [$];
    logic [DW:0] got_q [$];
    int          hs_cyc [$];
    int          done_cnt, done_cyc, first_lat, stall_err, timed_out;

    always #5 clk = ~clk;

    read_sram_puf #(.APPEND_CSUM(1'b1)) dut_a (
        .uprocessor_clk(clk), .rst(rst), .start(start_a), .abort(abort), .busy(busy_a),
        .ram_addr(ram_addr_a), .ram_rden(ram_rden_a), .ram_q(ram_q_a),
        .dout(dout_a), .dout_valid(valid_a), .dout_ready(dout_ready),
        .dout_last(last_a), .done(done_a)
    );

    read_sram_puf #(.APPEND_CSUM(1'b0)) dut_b (
        .uprocessor_clk(clk), .rst(rst), .start(start_b), .abort(abort), .busy(busy_b),
        .ram_addr(ram_addr_b), .ram_rden(ram_rden_b), .ram_q(ram_q_b),
        .dout(dout_b), .dout_valid(valid_b), .dout_ready(dout_ready),
        .dout_last(last_b), .done(done_b)
    );

    // Synchronous-read RAM models, one read port per reader.
    always @(posedge clk) if (ram_rden_a) ram_q_a <= mem[ram_addr_a];
    always @(posedge clk) if (ram_rden_b) ram_q_b <= mem[ram_addr_b];

    function automatic void build_expected(input bit append);
        logic [DW-1:0] c;
        c = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({(i == DEPTH - 1) && !append, mem[i]});
            c = c ^ mem[i];
        end
        if (append) exp_q.push_back({1'b1, c});
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
    endfunction

    // Drives ready and records accepted bytes; stops early at stop_at (byte held, ready low).
    task automatic collect(input bit dut2, input bit rand_ready, input int stop_at, input int restart_at);
        int            c;
        bit            restarted;
        logic          pv, pr, pl, v, l, dn;
        logic [DW-1:0] pd, d;
        c = 0; restarted = 0; pv = 0; pr = 0; pl = 0; pd = '0;
        got_q.delete(); hs_cyc.delete();
        done_cnt = 0; done_cyc = -1; first_lat = -1; stall_err = 0; timed_out = 0;
        forever begin
            @(negedge clk);
            c++;
            start_a = 1'b0;
            start_b = 1'b0;
            v  = dut2 ? valid_b : valid_a;
            d  = dut2 ? dout_b  : dout_a;
            l  = dut2 ? last_b  : last_a;
            dn = dut2 ? done_b  : done_a;
            if (dn) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (v && first_lat < 0) first_lat = c;
            if (pv && !pr && v && (d !== pd || l !== pl)) stall_err++;
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            if (c >= 3000) begin timed_out = 1; break; end
            if (stop_at >= 0 && v && got_q.size() == stop_at) begin
                dout_ready = 1'b0;
                break;
            end
            if (restart_at >= 0 && !restarted && v && got_q.size() == restart_at) begin
                if (dut2) start_b = 1'b1; else start_a = 1'b1;
                restarted = 1;
            end
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v && dout_ready) begin
                got_q.push_back({l, d});
                hs_cyc.push_back(c);
            end
            pv = v; pr = dout_ready; pd = d; pl = l;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start_a = 0; start_b = 0; abort = 0; dout_ready = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ram_addr_a, ram_rden_a, dout_a, valid_a, last_a, done_a, busy_a} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_a: got %h want 0", {ram_addr_a, ram_rden_a, dout_a, valid_a, last_a, done_a, busy_a});
        end
        n_cmp++;
        if ({ram_addr_b, ram_rden_b, dout_b, valid_b, last_b, done_b, busy_b} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_b: got %h want 0", {ram_addr_b, ram_rden_b, dout_b, valid_b, last_b, done_b, busy_b});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        logic [DW:0] g, e;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        build_expected(1'b1);
        @(negedge clk); start_a = 1'b1;
        collect(1'b0, 1'b0, -1, -1);
        n_cmp++; if (timed_out != 0) begin n_err++; $display("FAIL ramp_timeout: got %0d want 0", timed_out); end
        n_cmp++; if (first_lat != 3) begin n_err++; $display("FAIL ramp_latency: got %0d want 3", first_lat); end
        n_cmp++; if (got_q.size() != DEPTH + 1) begin n_err++; $display("FAIL ramp_count: got %0d want %0d", got_q.size(), DEPTH + 1); end
        n_cmp++;
        if (hs_cyc.size() < 2 || hs_cyc[1] - hs_cyc[0] != 3) begin
            n_err++; $display("FAIL ramp_spacing: got %0d want 3", hs_cyc.size() < 2 ? -1 : hs_cyc[1] - hs_cyc[0]);
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ramp_done_count: got %0d want 1", done_cnt); end
        n_cmp++;
        if (hs_cyc.size() == 0 || done_cyc - hs_cyc[hs_cyc.size() - 1] != 1) begin
            n_err++; $display("FAIL ramp_done_delay: got %0d want 1", hs_cyc.size() == 0 ? -1 : done_cyc - hs_cyc[hs_cyc.size() - 1]);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL ramp_byte: got last/data %h want %h", g, e); end
        end
    endtask

    task automatic test_stall();
        logic [DW:0] g, e;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[17] = 8'h5A;
        build_expected(1'b1);
        @(negedge clk); start_a = 1'b1;
        collect(1'b0, 1'b1, -1, -1);
        n_cmp++; if (timed_out != 0) begin n_err++; $display("FAIL stall_timeout: got %0d want 0", timed_out); end
        n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
        n_cmp++; if (got_q.size() != DEPTH + 1) begin n_err++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), DEPTH + 1); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL stall_byte: got last/data %h want %h", g, e); end
        end
    endtask

    task automatic test_no_csum();
        logic [DW:0] g, e;
        fill_random();
        mem[DEPTH - 1] = 8'hC3;
        build_expected(1'b0);
        @(negedge clk); start_b = 1'b1;
        collect(1'b1, 1'b0, -1, -1);
        n_cmp++; if (timed_out != 0) begin n_err++; $display("FAIL nocsum_timeout: got %0d want 0", timed_out); end
        n_cmp++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL nocsum_count: got %0d want %0d", got_q.size(), DEPTH); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL nocsum_done_count: got %0d want 1", done_cnt); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL nocsum_byte: got last/data %h want %h", g, e); end
        end
    endtask

    task automatic test_abort();
        logic [DW:0] g, e;
        int          dn_seen;
        fill_random();
        build_expected(1'b1);
        @(negedge clk); start_a = 1'b1;
        collect(1'b0, 1'b0, 10, -1);
        n_cmp++; if (got_q.size() != 10) begin n_err++; $display("FAIL abort_prefix_count: got %0d want 10", got_q.size()); end
        n_cmp++; if (valid_a !== 1'b1 || dout_a !== mem[10]) begin n_err++; $display("FAIL abort_held_byte: got v=%b d=%h want v=1 d=%h", valid_a, dout_a, mem[10]); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL abort_prefix_byte: got last/data %h want %h", g, e); end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({valid_a, last_a, ram_rden_a, busy_a, done_a} !== 5'b0) begin
            n_err++; $display("FAIL abort_idle: got v/l/rden/busy/done %b want 00000", {valid_a, last_a, ram_rden_a, busy_a, done_a});
        end
        dn_seen = 0;
        repeat (5) begin @(negedge clk); if (done_a) dn_seen++; end
        n_cmp++; if (dn_seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dn_seen); end
        build_expected(1'b1);
        start_a = 1'b1;
        collect(1'b0, 1'b0, -1, -1);
        n_cmp++; if (got_q.size() != DEPTH + 1) begin n_err++; $display("FAIL abort_replay_count: got %0d want %0d", got_q.size(), DEPTH + 1); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL abort_replay_done: got %0d want 1", done_cnt); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL abort_replay_byte: got last/data %h want %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        int dn_seen;
        fill_random();
        @(negedge clk); start_a = 1'b1;
        collect(1'b0, 1'b0, 40, -1);
        n_cmp++; if (got_q.size() != 40) begin n_err++; $display("FAIL rstmid_prefix_count: got %0d want 40", got_q.size()); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_addr_a, ram_rden_a, dout_a, valid_a, last_a, done_a, busy_a} !== 19'd0) begin
            n_err++; $display("FAIL rstmid_immediate: got %h want 0", {ram_addr_a, ram_rden_a, dout_a, valid_a, last_a, done_a, busy_a});
        end
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        rst = 1'b0;
        dn_seen = 0;
        repeat (4) begin @(negedge clk); if (done_a || valid_a || busy_a) dn_seen++; end
        n_cmp++; if (dn_seen != 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", dn_seen); end
        n_cmp++; if (ram_addr_a !== '0) begin n_err++; $display("FAIL rstmid_addr: got %h want 00", ram_addr_a); end
    endtask

    task automatic test_restart_busy();
        logic [DW:0] g, e;
        fill_random();
        build_expected(1'b1);
        @(negedge clk); start_a = 1'b1;
        collect(1'b0, 1'b0, -1, 5);
        n_cmp++; if (timed_out != 0) begin n_err++; $display("FAIL restart_timeout: got %0d want 0", timed_out); end
        n_cmp++; if (got_q.size() != DEPTH + 1) begin n_err++; $display("FAIL restart_count: got %0d want %0d", got_q.size(), DEPTH + 1); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL restart_byte: got last/data %h want %h", g, e); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_no_csum();
        test_abort();
        test_reset_mid();
        test_restart_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/read_sram_puf.md
Name: read_sram_puf

Overview:
Read-back engine for the 64-entry SRAM PUF store written by the microprocessor byte-capture path. On a start pulse it reads every RAM word in address order and streams each byte to the microprocessor over a valid/ready handshake. It can append a one-byte XOR checksum and flags the final byte. It owns the RAM read port (address/rden) and sits between the `ram` instance and the microprocessor data-in bus.

Parameters:
ADDR_W, 6, RAM address width
DATA_W, 8, RAM/stream data width
DEPTH, 64, number of words read per pass (must be ≤ 2**ADDR_W)
APPEND_CSUM, 1, 1 = emit XOR checksum byte after the last RAM word; 0 = no checksum

Ports:
uprocessor_clk  in  1  sole clock; all logic on posedge
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to begin a read pass; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE at next edge
busy  out  1  high whenever state ≠ IDLE
ram_addr  out  ADDR_W  RAM read address (registered)
ram_rden  out  1  RAM read enable (registered)
ram_q  in  DATA_W  RAM read data; valid the cycle after address is sampled
dout  out  DATA_W  stream byte to microprocessor (registered)
dout_valid  out  1  dout holds a byte
dout_ready  in  1  microprocessor accepts byte when valid && ready at an edge
dout_last  out  1  qualifies the final byte of the pass (checksum byte, or word DEPTH-1 if APPEND_CSUM=0)
done  out  1  one-cycle pulse after the final byte handshake

Behaviour:
- Reset (async): state=IDLE; ram_addr=0, ram_rden=0, dout=0, dout_valid=0, dout_last=0, done=0, busy=0, word counter=0, checksum=0.
- FSM states:
  - IDLE: busy=0. On start=1, go to ISSUE with counter=0, ram_addr=0, ram_rden=1, checksum=0.
  - ISSUE: the RAM samples the address at this edge. Go to CAPTURE; ram_rden drops to 0.
  - CAPTURE: ram_q is valid. At the edge: dout<=ram_q, checksum<=checksum^ram_q, dout_valid<=1, dout_last<=(counter==DEPTH-1 && !APPEND_CSUM). Go to PRESENT.
  - PRESENT: hold dout/dout_valid/dout_last stable until valid&&ready. On handshake:
    - counter<DEPTH-1: counter++, ram_addr<=counter+1, ram_rden<=1, dout_valid<=0, go to ISSUE.
    - counter==DEPTH-1 and APPEND_CSUM: dout<=checksum, dout_last<=1, dout_valid stays 1, go to CSUM.
    - otherwise: dout_valid<=0, dout_last<=0, done<=1, go to IDLE.
  - CSUM: hold the checksum byte until handshake, then dout_valid<=0, dout_last<=0, done<=1, go to IDLE.
- Timing:
  - Latency from start to first dout_valid: 3 edges (IDLE→ISSUE→CAPTURE→PRESENT).
  - Minimum spacing is 3 cycles per byte with ready held high.
- Counter and address: ram_addr never wraps mid-pass; the counter terminates at DEPTH-1. Counter width is ADDR_W+1 so DEPTH=2**ADDR_W is legal.
- Checksum: bitwise XOR of all DEPTH bytes, DATA_W wide. It is computed in CAPTURE, so it is independent of stall length.
- start while busy: ignored, no effect.
- abort: takes priority over all transitions in any non-IDLE state. Next edge forces IDLE, dout_valid=0, dout_last=0, ram_rden=0; done is not pulsed. abort in IDLE has no effect.
- abort and start together in IDLE: start wins.
- rst mid-pass: immediate return to reset values; no done.
- dout_ready while dout_valid=0: ignored.

Decomposition:
- Shared package holds:
  - PUF_ADDR_W=6, PUF_DATA_W=8, PUF_DEPTH=64 (shared with the capture path).
  - FSM state encoding: IDLE, ISSUE, CAPTURE, PRESENT, CSUM.
- Single module, no sub-module required. The RAM instance stays at the top level, and the capture path and this reader are muxed onto its address port there.

Test Plan:
- RAM[i]=i for i=0..63, start pulse, ready held 1 → bytes 0x00..0x3F in order, then checksum 0x00 with dout_last=1. done pulses once, 1 cycle after the last handshake. First valid appears 3 cycles after start.
- RAM all 0x00 except RAM[17]=0x5A; ready toggled 1/0 pseudo-randomly → dout stable during every stall, 65 bytes total, checksum byte 0x5A.
- APPEND_CSUM=0, RAM[63]=0xC3 → 64 bytes, dout_last=1 only on 0xC3, then done.
- abort asserted while PRESENT holds byte 10 → next cycle IDLE, dout_valid=0, no done. A new start replays from address 0.
- rst asserted asynchronously mid-stall at byte 40 → outputs go to reset values immediately; start pulses during the pass and during reset are ignored; ram_addr=0.
- start re-pulsed while busy at byte 5 → stream unaffected, exactly 65 bytes, one done.
